// File: rtl/config_arbiter.sv
// Round-robin arbiter that serializes two requesters' configuration commands onto
// the parameter store port, with a bounded wait for the store's done/error status.
module config_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic [2:0]        a_type,
  input  logic signed [7:0] a_val1,
  input  logic signed [7:0] a_val2,
  output logic              a_ack,
  output logic              a_ok,
  output logic              a_err,
  input  logic              b_req,
  input  logic [2:0]        b_type,
  input  logic signed [7:0] b_val1,
  input  logic signed [7:0] b_val2,
  output logic              b_ack,
  output logic              b_ok,
  output logic              b_err,
  input  logic              cfg_lock,
  output logic              config_valid,
  output logic [2:0]        config_type,
  output logic signed [7:0] config_value1,
  output logic signed [7:0] config_value2,
  input  logic              config_done,
  input  logic              config_error,
  output logic              busy,
  output logic              cfg_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            owner_q, owner_d;   // 0 = A, 1 = B
  logic            last_q, last_d;     // requester granted most recently
  logic            grant_s, res_ok_s, res_err_s, res_to_s;

  logic            valid_q, valid_d;
  logic            a_ack_q, a_ack_d, a_ok_q, a_ok_d, a_err_q, a_err_d;
  logic            b_ack_q, b_ack_d, b_ok_q, b_ok_d, b_err_q, b_err_d;
  logic            busy_q, busy_d, to_q, to_d;
  logic [2:0]      type_q, type_d;
  logic [7:0]      v1_q, v1_d, v2_q, v2_d;

  // State, sequencing bookkeeping and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      valid_q <= 1'b0;
      a_ack_q <= 1'b0;
      a_ok_q  <= 1'b0;
      a_err_q <= 1'b0;
      b_ack_q <= 1'b0;
      b_ok_q  <= 1'b0;
      b_err_q <= 1'b0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      type_q  <= 3'd0;
      v1_q    <= 8'd0;
      v2_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      a_ack_q <= a_ack_d;
      a_ok_q  <= a_ok_d;
      a_err_q <= a_err_d;
      b_ack_q <= b_ack_d;
      b_ok_q  <= b_ok_d;
      b_err_q <= b_err_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
      type_q  <= type_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
    end
  end

  // Next state: arbitration in IDLE, status/timeout resolution in WAIT
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    grant_s   = 1'b0;
    res_ok_s  = 1'b0;
    res_err_s = 1'b0;
    res_to_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!cfg_lock && (a_req || b_req)) begin
          grant_s = 1'b1;
          owner_d = (a_req && b_req) ? ~last_q : b_req;
          last_d  = owner_d;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // error takes precedence over a coincident done
        if (config_error) begin
          res_err_s = 1'b1;
          state_d   = S_RESP;
        end else if (config_done) begin
          res_ok_s = 1'b1;
          state_d  = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          res_err_s = 1'b1;
          res_to_s  = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output next values, registered so every pulse lands one cycle after its decision
  always_comb begin
    valid_d = grant_s;
    a_ack_d = grant_s & ~owner_d;
    b_ack_d = grant_s & owner_d;
    a_ok_d  = res_ok_s & ~owner_q;
    a_err_d = res_err_s & ~owner_q;
    b_ok_d  = res_ok_s & owner_q;
    b_err_d = res_err_s & owner_q;
    to_d    = res_to_s;
    busy_d  = (state_d != S_IDLE);
    if (grant_s) begin
      if (owner_d) begin
        type_d = b_type;
        v1_d   = b_val1;
        v2_d   = b_val2;
      end else begin
        type_d = a_type;
        v1_d   = a_val1;
        v2_d   = a_val2;
      end
    end else begin
      type_d = type_q;
      v1_d   = v1_q;
      v2_d   = v2_q;
    end
  end

  assign config_valid  = valid_q;
  assign config_type   = type_q;
  assign config_value1 = v1_q;
  assign config_value2 = v2_q;
  assign a_ack         = a_ack_q;
  assign a_ok          = a_ok_q;
  assign a_err         = a_err_q;
  assign b_ack         = b_ack_q;
  assign b_ok          = b_ok_q;
  assign b_err         = b_err_q;
  assign busy          = busy_q;
  assign cfg_timeout   = to_q;

endmodule
